// File: rtl/psk_pkg.sv
// Shared PSK receive-path constants and the output holding-register state encoding.
package psk_pkg;

   localparam int unsigned N_BITS_DEFAULT = 2;
   localparam int unsigned WORD_W         = 8;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } hold_state_e;

endpackage

// File: rtl/bits_gather_hold.sv
// Output holding register for bits_gather: O/O_valid handshake, overflow pulse
// and the bypass override that writes a single-cycle word.
module bits_gather_hold
   import psk_pkg::*;
#(
   parameter int unsigned M = WORD_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [M-1:0] word_i,
   input  logic         byp_load_i,
   input  logic         byp_valid_i,
   input  logic [M-1:0] byp_word_i,
   input  logic         O_ready_i,
   output logic [M-1:0] O_o,
   output logic         O_valid_o,
   output logic         ovf_o
);

   hold_state_e  state_q;
   logic [M-1:0] o_q;
   logic         valid_q;
   logic         ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         o_q     <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         ovf_q <= 1'b0;
         if (byp_load_i) begin
            // Bypass words never enter HOLD, so IDLE drops O_valid on the next clk.
            state_q <= IDLE;
            o_q     <= byp_word_i;
            valid_q <= byp_valid_i;
         end else begin
            case (state_q)
               IDLE: begin
                  valid_q <= 1'b0;
                  if (load_i) begin
                     o_q     <= word_i;
                     valid_q <= 1'b1;
                     state_q <= HOLD;
                  end
               end
               HOLD: begin
                  if (O_ready_i) begin
                     if (load_i) begin
                        o_q <= word_i;
                     end else begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                     end
                  end else if (load_i) begin
                     ovf_q <= 1'b1;
                  end
               end
            endcase
         end
      end
   end

   assign O_o       = o_q;
   assign O_valid_o = valid_q;
   assign ovf_o     = ovf_q;

endmodule

// File: rtl/bits_gather.sv
// Serial-to-parallel symbol packer: N bits LSB-first per 1.024 MHz symbol,
// sampled on the 2.048 MHz enable, with a single-bit bypass path.
module bits_gather
   import psk_pkg::*;
#(
   parameter int unsigned N                = N_BITS_DEFAULT,
   parameter int unsigned M                = WORD_W,
   parameter int unsigned BYPASS_SELECTION = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ce_1M,
   input  logic         ce_2M,
   input  logic         bypass,
   input  logic         I,
   input  logic         I_valid,
   output logic         I_ready,
   output logic [M-1:0] O,
   output logic         O_valid,
   input  logic         O_ready,
   output logic         sym_err,
   output logic         ovf
);

   localparam logic [3:0] LAST_IDX = 4'(N - 1);

   logic [N-1:0] acc_q;
   logic [3:0]   bit_cnt_q;
   logic         bad_q;
   logic         skip_q;
   logic         sym_err_q;

   logic [M-1:0] word_d;
   logic [M-1:0] byp_word_d;
   logic         good_d;
   logic         byp_load_d;

   // The completing sample is merged directly as the MSB of the symbol.
   always_comb begin
      word_d         = '0;
      word_d[N-1:0]  = {I, acc_q[N-1:1]};
      byp_word_d     = '0;
      byp_word_d[BYPASS_SELECTION] = I & I_valid;
   end

   assign good_d     = ce_1M & ~bypass & ~skip_q & ~bad_q & I_valid & (bit_cnt_q == LAST_IDX);
   assign byp_load_d = ce_1M & bypass;

   // skip_q marks a symbol interrupted by bypass so it is dropped without sym_err.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q     <= '0;
         bit_cnt_q <= '0;
         bad_q     <= 1'b0;
         skip_q    <= 1'b0;
         sym_err_q <= 1'b0;
      end else begin
         sym_err_q <= 1'b0;
         if (bypass) begin
            if (ce_1M) begin
               acc_q     <= '0;
               bit_cnt_q <= '0;
               bad_q     <= 1'b0;
               skip_q    <= 1'b0;
            end else if (ce_2M || (bit_cnt_q != '0) || bad_q) begin
               skip_q <= 1'b1;
            end
         end else if (ce_1M) begin
            acc_q     <= '0;
            bit_cnt_q <= '0;
            bad_q     <= 1'b0;
            skip_q    <= 1'b0;
            sym_err_q <= ~skip_q & ~good_d;
         end else if (ce_2M) begin
            acc_q <= {I, acc_q[N-1:1]};
            if (bit_cnt_q != 4'hF) begin
               bit_cnt_q <= bit_cnt_q + 4'd1;
            end
            if (!I_valid || (bit_cnt_q >= LAST_IDX)) begin
               bad_q <= 1'b1;
            end
         end
      end
   end

   bits_gather_hold #(
      .M(M)
   ) u_hold (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (good_d),
      .word_i     (word_d),
      .byp_load_i (byp_load_d),
      .byp_valid_i(I_valid),
      .byp_word_i (byp_word_d),
      .O_ready_i  (O_ready),
      .O_o        (O),
      .O_valid_o  (O_valid),
      .ovf_o      (ovf)
   );

   assign sym_err = sym_err_q;
   assign I_ready = ~O_valid | O_ready;

endmodule
